// File: rtl/f_register_file.sv
// rtl/f_register_file.sv - architectural register file with backup-stack snapshot/restore sequencing
// Two combinational read ports, one write port, and a call/ret FSM driving the backup stack handshake.
module f_register_file #(
  parameter int NUM_REGS = 16,
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int TIMEOUT  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         wAddr,
  input  logic [WIDTH-1:0]          wData,
  input  logic [ADDR_W-1:0]         rAddr1,
  input  logic [ADDR_W-1:0]         rAddr2,
  output logic [WIDTH-1:0]          rData1,
  output logic [WIDTH-1:0]          rData2,
  input  logic                      call,
  input  logic                      ret,
  output logic                      backup,
  output logic                      restore,
  output logic [NUM_REGS*WIDTH-1:0] snapshot,
  input  logic [NUM_REGS*WIDTH-1:0] restoreData,
  input  logic                      restoreValid,
  output logic                      busy,
  output logic                      restoreErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SAVE      = 2'd1,
    LOAD_WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               backup_q, backup_d;
  logic               restore_q, restore_d;
  logic               busy_q, busy_d;
  logic               do_load;
  logic               wr_en;
  logic [WIDTH-1:0]   regs_q [NUM_REGS];
  logic [WIDTH-1:0]   regs_d [NUM_REGS];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; call wins over ret, requests while busy are dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    do_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (call) begin
          state_d = SAVE;
        end else if (ret) begin
          state_d = LOAD_WAIT;
          cnt_d   = '0;
        end
      end
      SAVE: begin
        state_d = IDLE;
      end
      LOAD_WAIT: begin
        if (restoreValid) begin
          do_load = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the strobes come straight off flops
  always_comb begin
    backup_d  = (state_d == SAVE);
    restore_d = (state_d == LOAD_WAIT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      backup_q  <= 1'b0;
      restore_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      backup_q  <= backup_d;
      restore_q <= restore_d;
      busy_q    <= busy_d;
    end
  end

  assign backup     = backup_q;
  assign restore    = restore_q;
  assign busy       = busy_q;
  assign restoreErr = err_q;

  assign wr_en = we && (state_q == IDLE) && (wAddr != '0);

  // Writes only happen in IDLE and reloads only in LOAD_WAIT, so they never collide
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (do_load) begin
        regs_d[i] = restoreData[i*WIDTH +: WIDTH];
      end
      if (wr_en && (wAddr == ADDR_W'(i))) begin
        regs_d[i] = wData;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Address 0 and anything past the last register fall through to zero
  always_comb begin
    rData1 = '0;
    rData2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rAddr1 == ADDR_W'(i)) begin
        rData1 = regs_q[i];
      end
      if (rAddr2 == ADDR_W'(i)) begin
        rData2 = regs_q[i];
      end
    end
  end

  always_comb begin
    snapshot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      snapshot[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_f_register_file.sv
// tb/tb_f_register_file.sv - directed-vector bench for f_register_file
module tb_f_register_file;

  logic         clk;
  logic         rst_n;
  logic         we;
  logic [3:0]   wAddr;
  logic [15:0]  wData;
  logic [3:0]   rAddr1;
  logic [3:0]   rAddr2;
  logic [15:0]  rData1;
  logic [15:0]  rData2;
  logic         call;
  logic         ret;
  logic         backup;
  logic         restore;
  logic [255:0] snapshot;
  logic [255:0] restoreData;
  logic         restoreValid;
  logic         busy;
  logic         restoreErr;

  int vectors;
  int miscompares;

  logic [15:0]  exp_regs [16];
  logic [255:0] saved_img;
  logic [255:0] aa_img;
  int           busy_cnt;
  int           rest_cnt;

  f_register_file dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .wAddr        (wAddr),
    .wData        (wData),
    .rAddr1       (rAddr1),
    .rAddr2       (rAddr2),
    .rData1       (rData1),
    .rData2       (rData2),
    .call         (call),
    .ret          (ret),
    .backup       (backup),
    .restore      (restore),
    .snapshot     (snapshot),
    .restoreData  (restoreData),
    .restoreValid (restoreValid),
    .busy         (busy),
    .restoreErr   (restoreErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] pack_exp();
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p[i*16 +: 16] = exp_regs[i];
    return p;
  endfunction

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    we           = 1'b0;
    wAddr        = '0;
    wData        = '0;
    rAddr1       = '0;
    rAddr2       = '0;
    call         = 1'b0;
    ret          = 1'b0;
    restoreData  = '0;
    restoreValid = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;

    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_backup", backup, 1'b0);
    check("rst_restore", restore, 1'b0);
    check("rst_err", restoreErr, 1'b0);
    check("rst_snapshot", snapshot, 256'd0);

    // Fill r1..r15, then try to write r0
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; wAddr = 4'(i); wData = 16'(16'h0101 * i);
      exp_regs[i] = 16'(16'h0101 * i);
      tick();
    end
    we = 1'b1; wAddr = 4'd0; wData = 16'hFFFF;
    tick();
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rAddr1 = 4'(i); rAddr2 = 4'(i);
      #1;
      check($sformatf("rd1_r%0d", i), rData1, exp_regs[i]);
      check($sformatf("rd2_r%0d", i), rData2, exp_regs[i]);
    end

    // Write coincident with call lands in the snapshot
    we = 1'b1; wAddr = 4'd3; wData = 16'hBEEF; call = 1'b1;
    exp_regs[3] = 16'hBEEF;
    tick();
    we = 1'b0; call = 1'b0;
    check("save_backup", backup, 1'b1);
    check("save_busy", busy, 1'b1);
    check("save_r3", snapshot[63:48], 16'hBEEF);
    check("save_image", snapshot, pack_exp());
    saved_img = pack_exp();
    tick();
    check("save_end_backup", backup, 1'b0);
    check("save_end_busy", busy, 1'b0);

    // Clobber everything, then restore the saved image
    aa_img = '0;
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; wAddr = 4'(i); wData = 16'h00AA;
      aa_img[i*16 +: 16] = 16'h00AA;
      tick();
    end
    we = 1'b0;
    check("aa_image", snapshot, aa_img);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("ret_restore", restore, 1'b1);
    busy_cnt = 0;
    for (int c = 0; c < 20 && busy; c++) begin
      busy_cnt++;
      if (busy_cnt == 3) begin
        restoreValid = 1'b1;
        restoreData  = saved_img | 256'hDEAD;
      end
      tick();
    end
    restoreValid = 1'b0;
    check("ret_busy_cycles", busy_cnt, 3);
    check("ret_restore_low", restore, 1'b0);
    check("ret_image", snapshot, saved_img);
    rAddr1 = 4'd0; rAddr2 = 4'd3;
    #1;
    check("ret_r0", rData1, 16'h0000);
    check("ret_r3", rData2, 16'hBEEF);
    check("ret_err", restoreErr, 1'b0);

    // Timeout with restoreValid held low
    ret = 1'b1;
    tick();
    ret = 1'b0;
    rest_cnt = 0;
    for (int c = 0; c < 20 && restore; c++) begin
      rest_cnt++;
      tick();
    end
    check("to_restore_cycles", rest_cnt, 8);
    check("to_err", restoreErr, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_image", snapshot, saved_img);
    call = 1'b1;
    tick();
    call = 1'b0;
    check("to_call_backup", backup, 1'b1);
    tick();
    check("to_call_done", backup, 1'b0);
    check("to_err_sticky", restoreErr, 1'b1);

    // call+ret together, then call/we while busy
    call = 1'b1; ret = 1'b1;
    tick();
    ret = 1'b0;
    check("cr_backup", backup, 1'b1);
    check("cr_restore", restore, 1'b0);
    we = 1'b1; wAddr = 4'd5; wData = 16'h1234;
    tick();
    call = 1'b0; we = 1'b0;
    check("busy_call_backup", backup, 1'b0);
    check("busy_call_busy", busy, 1'b0);
    check("cr_restore2", restore, 1'b0);
    rAddr1 = 4'd5;
    #1;
    check("busy_we_r5", rData1, exp_regs[5]);
    tick();
    check("cr_restore3", restore, 1'b0);
    check("cr_idle", busy, 1'b0);

    // Reset mid LOAD_WAIT with valid data present
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("rl_restore", restore, 1'b1);
    restoreValid = 1'b1;
    restoreData  = {256{1'b1}};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    restoreValid = 1'b0;
    check("rl_snapshot", snapshot, 256'd0);
    check("rl_restore_low", restore, 1'b0);
    check("rl_busy", busy, 1'b0);
    check("rl_err", restoreErr, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/f_register_file.md
Name: f_register_file

Overview:
- Architectural register file: NUM_REGS x WIDTH bits, with two read ports and one write port.
- Directly upstream and downstream of the f-register backup stack:
  - drives its backup/restore strobes and its 256-bit dataIn snapshot;
  - consumes its dataOut/restoreOut to bulk-reload every register.
- A small FSM turns single-cycle call/ret requests from the control unit into correctly timed backup/restore handshakes.
- While a handshake is in progress, busy stalls the pipeline.

Parameters:
- NUM_REGS, 16, number of registers; register 0 is hardwired to zero.
- WIDTH, 16, bits per register; NUM_REGS*WIDTH = 256 = snapshot width.
- ADDR_W, 4, register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- TIMEOUT, 8, maximum cycles spent waiting for restoreValid before abort.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- we, input, 1: write enable.
- wAddr, input, ADDR_W: write address.
- wData, input, WIDTH: write data.
- rAddr1, input, ADDR_W: read address, port 1.
- rAddr2, input, ADDR_W: read address, port 2.
- rData1, output, WIDTH: read data, port 1.
- rData2, output, WIDTH: read data, port 2.
- call, input, 1: request snapshot push (one-cycle pulse).
- ret, input, 1: request snapshot pop and reload (one-cycle pulse).
- backup, output, 1: push strobe to the backup stack.
- restore, output, 1: pop request to the backup stack.
- snapshot, output, NUM_REGS*WIDTH: packed register contents; feeds the stack's dataIn.
- restoreData, input, NUM_REGS*WIDTH: packed data from the stack's dataOut.
- restoreValid, input, 1: the stack's restoreOut.
- busy, output, 1: FSM not IDLE; control must stall.
- restoreErr, output, 1: sticky flag, restore timed out.

Behaviour:
- Packing: register i occupies snapshot[i*WIDTH +: WIDTH]. The same layout applies to restoreData.
- snapshot is continuously driven from the register contents (registered state, no extra delay).
- Reads:
  - Combinational from register state; no write-through bypass, so a write becomes visible the cycle after it is accepted.
  - Address 0 always reads 0.
  - An address >= NUM_REGS reads 0.
- Writes:
  - Accepted when we=1, state==IDLE and wAddr is nonzero and < NUM_REGS.
  - Ignored otherwise, including any write attempted while busy=1.
- Reset (rst_n=0 at a clock edge):
  - All registers become 0.
  - backup=0, restore=0, busy=0, restoreErr=0, state=IDLE, timeout counter=0.
  - A reset during SAVE or LOAD_WAIT aborts the operation; no partial reload happens.
- FSM states: IDLE, SAVE, LOAD_WAIT.
  - IDLE:
    - call=1 → SAVE. call has priority when call and ret are both high; that ret is dropped.
    - ret=1 (call=0) → LOAD_WAIT; counter cleared.
    - A write and a call in the same cycle: the write is accepted and is included in the snapshot.
  - SAVE:
    - backup=1 and busy=1 for exactly one cycle; snapshot is stable during it.
    - Next state IDLE unconditionally.
  - LOAD_WAIT:
    - restore=1 and busy=1.
    - Each cycle, if restoreValid=1: registers 1..NUM_REGS-1 load from restoreData on that edge, register 0 stays 0, next state IDLE.
    - Else the counter increments. When the counter reaches TIMEOUT-1 without valid: restoreErr<=1, next state IDLE, registers unchanged.
  - call/ret while busy=1 are ignored (not queued).
- Outputs backup, restore and busy are registered, decoded from state.
- Latency:
  - call sampled at edge N → backup high for the cycle after edge N → busy low after edge N+1.
  - ret sampled at edge N → restore high after edge N. With restoreValid high in that same cycle, the reload happens at edge N+1 and restore/busy drop after edge N+1. Minimum busy duration: 1 cycle.
- restoreErr is sticky; only reset clears it.

Test Plan:
- Reset, then write r1..r15 = 16'h0101*i and read each back on both ports → rDataX = 16'h0101*i. A write to r0 of 16'hFFFF → rData1 = 0.
- Same-cycle write r3=16'hBEEF with call → next cycle backup=1, busy=1, snapshot[63:48]=16'hBEEF. The following cycle backup=0, busy=0.
- Backup, overwrite all registers with 16'h00AA, then ret, with the bench asserting restoreValid 2 cycles after restore rises and driving the saved image → registers equal the pre-call values; busy high exactly 3 cycles; r0 still 0.
- ret with restoreValid held low → restore held for TIMEOUT=8 cycles, then restoreErr=1, busy=0, registers unchanged. A later call still works; restoreErr stays 1 until rst_n=0.
- call and ret high together in IDLE → only backup pulses, restore never rises. A call or we pulse issued while busy=1 has no effect.
- Assert rst_n=0 in the middle of LOAD_WAIT while restoreValid=1 → all registers 0, restore=0, busy=0 on the next cycle.
